// File: rtl/motor_pwm_decode.sv
// motor_pwm_decode: measures the fwd/rev PWM pair over one PWM period and
// reconstructs the signed drive command. The window is 2^WIN_BITS cycles.
// Optional macro MOTOR_DEC_SYNC_EN adds a 2-flop synchronizer on fwd and rev.
// Without the macro, fwd and rev are sampled directly.

module motor_pwm_decode #(
  parameter int unsigned WIN_BITS = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                fwd,
  input  logic                rev,
  output logic [WIN_BITS:0]   cmd,
  output logic                brake,
  output logic                err,
  output logic                valid
);

  // Full window count (line high every sample) and the largest encodable magnitude.
  localparam logic [WIN_BITS:0] Full   = {1'b1, {WIN_BITS{1'b0}}};
  localparam logic [WIN_BITS:0] MaxMag = {1'b0, {WIN_BITS{1'b1}}};
  localparam logic [WIN_BITS:0] Zero   = '0;

  logic fwd_s;
  logic rev_s;

`ifdef MOTOR_DEC_SYNC_EN
  logic [1:0] fwd_sync_q;
  logic [1:0] rev_sync_q;

  // Two-stage synchronizer; window boundaries are not shifted, so the first
  // window after reset sees two zero samples.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fwd_sync_q <= 2'b00;
      rev_sync_q <= 2'b00;
    end else begin
      fwd_sync_q <= {fwd_sync_q[0], fwd};
      rev_sync_q <= {rev_sync_q[0], rev};
    end
  end

  assign fwd_s = fwd_sync_q[1];
  assign rev_s = rev_sync_q[1];
`else
  assign fwd_s = fwd;
  assign rev_s = rev;
`endif

  logic [WIN_BITS-1:0] wcnt_q, wcnt_d;
  logic [WIN_BITS:0]   fcnt_q, fcnt_d;
  logic [WIN_BITS:0]   rcnt_q, rcnt_d;
  logic [WIN_BITS:0]   bcnt_q, bcnt_d;
  logic [WIN_BITS:0]   cmd_q, cmd_d;
  logic                brake_q, brake_d;
  logic                err_q, err_d;
  logic                valid_q, valid_d;

  logic                win_end;
  logic [WIN_BITS:0]   ftot, rtot, btot;
  logic [WIN_BITS:0]   fmag, rmag;

  // Next-state: accumulate this cycle's sample, classify on the last cycle of the window.
  always_comb begin
    win_end = (wcnt_q == {WIN_BITS{1'b1}});
    wcnt_d  = wcnt_q + 1'b1;

    // Totals include the current sample so the final cycle is counted.
    ftot = fcnt_q + {{WIN_BITS{1'b0}}, (fwd_s & ~rev_s)};
    rtot = rcnt_q + {{WIN_BITS{1'b0}}, (rev_s & ~fwd_s)};
    btot = bcnt_q + {{WIN_BITS{1'b0}}, (fwd_s & rev_s)};

    // A line high for the whole window saturates to the largest magnitude.
    fmag = (ftot == Full) ? MaxMag : ftot;
    rmag = (rtot == Full) ? MaxMag : rtot;

    fcnt_d  = ftot;
    rcnt_d  = rtot;
    bcnt_d  = btot;
    cmd_d   = cmd_q;
    brake_d = brake_q;
    err_d   = err_q;
    valid_d = win_end;

    if (win_end) begin
      fcnt_d = Zero;
      rcnt_d = Zero;
      bcnt_d = Zero;
      if (btot == Full) begin
        brake_d = 1'b1;
        cmd_d   = Zero;
        err_d   = 1'b0;
      end else if (btot == Zero && ftot == Zero && rtot == Zero) begin
        brake_d = 1'b0;
        cmd_d   = Zero;
        err_d   = 1'b0;
      end else if (btot == Zero && rtot == Zero) begin
        brake_d = 1'b0;
        cmd_d   = fmag;
        err_d   = 1'b0;
      end else if (btot == Zero && ftot == Zero) begin
        brake_d = 1'b0;
        cmd_d   = Zero - rmag;
        err_d   = 1'b0;
      end else begin
        // Mixed direction or partial overlap: flag it, keep the last good command.
        err_d = 1'b1;
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wcnt_q  <= '0;
      fcnt_q  <= '0;
      rcnt_q  <= '0;
      bcnt_q  <= '0;
      cmd_q   <= '0;
      brake_q <= 1'b0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      wcnt_q  <= wcnt_d;
      fcnt_q  <= fcnt_d;
      rcnt_q  <= rcnt_d;
      bcnt_q  <= bcnt_d;
      cmd_q   <= cmd_d;
      brake_q <= brake_d;
      err_q   <= err_d;
      valid_q <= valid_d;
    end
  end

  assign cmd   = cmd_q;
  assign brake = brake_q;
  assign err   = err_q;
  assign valid = valid_q;

endmodule

// File: tb/tb_motor_pwm_decode.sv
// Bench for motor_pwm_decode: table-driven PWM windows, hand sequences for the
// multi-cycle corners, and random windows, all checked every cycle against a
// window-counting reference model.

module tb_motor_pwm_decode;

  localparam int W   = 10;
  localparam int WIN = 1 << W;

  typedef logic [W:0] cmd_t;

  typedef struct {
    int   f_hi;
    int   f_ph;
    int   r_hi;
    int   r_ph;
    cmd_t cmd;
    logic brake;
    logic err;
  } vec_t;

  logic clk;
  logic rst_n;
  logic fwd;
  logic rev;
  cmd_t cmd;
  logic brake;
  logic err;
  logic valid;

  int vectors;
  int miscompares;

  motor_pwm_decode #(
    .WIN_BITS (W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .fwd   (fwd),
    .rev   (rev),
    .cmd   (cmd),
    .brake (brake),
    .err   (err),
    .valid (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state: sample counts in the current window.
  int   nf, nr, nb, k;
  logic h1f, h1r, h2f, h2r;
  cmd_t e_cmd;
  logic e_brake, e_err, e_valid;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic model_edge(input logic f, input logic r, input logic rn);
    logic sf, sr;
    int   mag;
    if (!rn) begin
      nf = 0; nr = 0; nb = 0; k = 0;
      h1f = 0; h1r = 0; h2f = 0; h2r = 0;
      e_cmd = '0; e_brake = 0; e_err = 0; e_valid = 0;
      return;
    end
`ifdef MOTOR_DEC_SYNC_EN
    sf = h2f; sr = h2r;
    h2f = h1f; h2r = h1r;
    h1f = f; h1r = r;
`else
    sf = f; sr = r;
`endif
    if (sf && sr) nb++;
    else if (sf) nf++;
    else if (sr) nr++;
    k++;
    e_valid = 0;
    if (k == WIN) begin
      e_valid = 1;
      if (nb == WIN) begin
        e_brake = 1; e_cmd = '0; e_err = 0;
      end else if (nb + nf + nr == 0) begin
        e_brake = 0; e_cmd = '0; e_err = 0;
      end else if (nb == 0 && nr == 0) begin
        mag = (nf > WIN - 1) ? WIN - 1 : nf;
        e_brake = 0; e_cmd = cmd_t'(mag); e_err = 0;
      end else if (nb == 0 && nf == 0) begin
        mag = (nr > WIN - 1) ? WIN - 1 : nr;
        e_brake = 0; e_cmd = cmd_t'(-mag); e_err = 0;
      end else begin
        e_err = 1;
      end
      nf = 0; nr = 0; nb = 0; k = 0;
    end
  endtask

  // One clock: drive inputs, advance the model at the edge, compare just after.
  task automatic step(input logic f, input logic r, input logic rn);
    fwd = f; rev = r; rst_n = rn;
    @(posedge clk);
    model_edge(f, r, rn);
    #1;
    cmp("cycle", {20'd0, cmd, brake, err, valid}, {20'd0, e_cmd, e_brake, e_err, e_valid});
  endtask

  task automatic run_window(input int f_hi, input int f_ph, input int r_hi, input int r_ph);
    logic f, r;
    for (int i = 0; i < WIN; i++) begin
      f = ((i + f_ph) % WIN) < f_hi;
      r = ((i + r_ph) % WIN) < r_hi;
      step(f, r, 1'b1);
    end
  endtask

  task automatic run_noise();
    for (int i = 0; i < WIN; i++) step(1'($urandom), 1'($urandom), 1'b1);
  endtask

  // Direct check of a window result against a hand-derived constant.
  task automatic check_win(input string name, input cmd_t c, input logic b, input logic e);
`ifndef MOTOR_DEC_SYNC_EN
    cmp(name, {20'd0, cmd, brake, err, valid}, {20'd0, c, b, e, 1'b1});
`endif
  endtask

  vec_t tbl[12];

  initial begin
    int n;
    int mode, hi, hi2;
    vectors = 0;
    miscompares = 0;
    fwd = 0; rev = 0; rst_n = 0;

    tbl[0]  = '{256,  0,   0,    0,   11'h100, 1'b0, 1'b0};
    tbl[1]  = '{256,  300, 0,    0,   11'h100, 1'b0, 1'b0};
    tbl[2]  = '{0,    0,   1,    500, 11'h7FF, 1'b0, 1'b0};
    tbl[3]  = '{0,    0,   1024, 0,   11'h401, 1'b0, 1'b0};
    tbl[4]  = '{1024, 0,   0,    0,   11'h3FF, 1'b0, 1'b0};
    tbl[5]  = '{1,    77,  0,    0,   11'h001, 1'b0, 1'b0};
    tbl[6]  = '{1024, 0,   1024, 0,   11'h000, 1'b1, 1'b0};
    tbl[7]  = '{512,  0,   512,  512, 11'h000, 1'b1, 1'b1};
    tbl[8]  = '{0,    0,   0,    0,   11'h000, 1'b0, 1'b0};
    tbl[9]  = '{0,    0,   700,  123, 11'h544, 1'b0, 1'b0};
    tbl[10] = '{1024, 0,   3,    0,   11'h544, 1'b0, 1'b1};
    tbl[11] = '{512,  0,   0,    0,   11'h200, 1'b0, 1'b0};

    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
    cmp("reset", {20'd0, cmd, brake, err, valid}, 32'd0);

`ifdef MOTOR_DEC_SYNC_EN
    // Constant forward drive: first window loses two samples to the synchronizer.
    for (int i = 0; i < WIN; i++) step(1'b1, 1'b0, 1'b1);
    cmp("sync_first", {20'd0, cmd, brake, err, valid}, {20'd0, 11'd1022, 3'b001});
    for (int i = 0; i < WIN; i++) step(1'b1, 1'b0, 1'b1);
    cmp("sync_second", {20'd0, cmd, brake, err, valid}, {20'd0, 11'd1023, 3'b001});
`endif

    for (int v = 0; v < 12; v++) begin
      run_window(tbl[v].f_hi, tbl[v].f_ph, tbl[v].r_hi, tbl[v].r_ph);
      check_win($sformatf("table_%0d", v), tbl[v].cmd, tbl[v].brake, tbl[v].err);
    end

    // Direction change at cycle 500 of a window following steady 0x200 forward.
    for (int i = 0; i < WIN; i++) begin
      if (i < 500) step(1'(i < 512), 1'b0, 1'b1);
      else         step(1'b0, 1'(i < 512), 1'b1);
    end
    check_win("dir_change_err", 11'h200, 1'b0, 1'b1);
    run_window(0, 0, 512, 0);
    check_win("dir_change_rev", 11'h600, 1'b0, 1'b0);

    // Reset at wcnt=700, then the next result must come a full window after release.
    for (int i = 0; i < 700; i++) step(1'(i < 256), 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    cmp("mid_reset", {20'd0, cmd, brake, err, valid}, 32'd0);
    n = 0;
    while (n < 2000) begin
      step(1'((n % WIN) < 256), 1'b0, 1'b1);
      n++;
      if (valid) break;
    end
    cmp("relaunch_latency", 32'(n), 32'(WIN));
    check_win("relaunch_cmd", 11'h100, 1'b0, 1'b0);

    // Random windows, checked by the model alone.
    for (int w = 0; w < 10; w++) begin
      mode = $urandom_range(0, 4);
      hi   = $urandom_range(0, WIN);
      hi2  = $urandom_range(0, WIN);
      case (mode)
        0: run_window(hi, $urandom_range(0, WIN - 1), 0, 0);
        1: run_window(0, 0, hi, $urandom_range(0, WIN - 1));
        2: run_window(hi, 5, hi, 5);
        3: run_window(hi, $urandom_range(0, WIN - 1), hi2, $urandom_range(0, WIN - 1));
        default: run_noise();
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/motor_pwm_decode.md
Name: motor_pwm_decode

Overview:
- Receive-side companion to the motor controller's PWM drive.
- Observes one motor's fwd/rev PWM pair and reconstructs the signed 11-bit drive command.
- Measures high-time over a fixed window equal to one PWM period, 2^WIN_BITS cycles.
- Sits beside the drive path; used for closed-loop self-check and for bench or scoreboard monitoring of drive outputs.

Parameters:
- WIN_BITS, 10, log2 of the measurement window in clk cycles; must equal the PWM counter width; legal range 2..10.

Ports:
- clk  input  1  system clock
- rst_n  input  1  synchronous active-low reset
- fwd  input  1  forward PWM line, same clock domain
- rev  input  1  reverse PWM line, same clock domain
- cmd  output  WIN_BITS+1  decoded signed command, two's complement, registered
- brake  output  1  last window decoded as brake (fwd and rev both high every cycle)
- err  output  1  last window was inconsistent
- valid  output  1  one-cycle pulse when cmd/brake/err update

Behaviour:
- Interface: one clock, clk. Reset rst_n is synchronous and active-low.
- Reset: all outputs are 0 (cmd=0, brake=0, err=0, valid=0). wcnt and all accumulators are cleared. Reset mid-window discards the partial window; a fresh window starts on the first cycle with rst_n=1.
- Window counter wcnt (WIN_BITS bits): increments every cycle and wraps from 2^WIN_BITS-1 to 0. A window is 2^WIN_BITS consecutive samples. No alignment to PWM edges is needed: any full period of a periodic PWM gives the exact high count.
- Accumulators, each WIN_BITS+1 bits (max 2^WIN_BITS):
  - fcnt: +1 when fwd=1 and rev=0
  - rcnt: +1 when rev=1 and fwd=0
  - bcnt: +1 when fwd=1 and rev=1
- End of window, on the edge where wcnt==max: this cycle's sample is included in the classification. Outputs update on that edge. Accumulators reload with 0 and then count from the next sample. valid=1 for exactly the following cycle.
- First valid occurs 2^WIN_BITS cycles after reset release.
- Classification, in priority order:
  1. bcnt==2^WIN_BITS → brake=1, cmd=0, err=0.
  2. bcnt==0, fcnt==0, rcnt==0 → coast: brake=0, cmd=0, err=0.
  3. bcnt==0, rcnt==0, fcnt>0 → cmd=+min(fcnt, 2^WIN_BITS-1), brake=0, err=0.
  4. bcnt==0, fcnt==0, rcnt>0 → cmd=-min(rcnt, 2^WIN_BITS-1) (two's complement in WIN_BITS+1 bits), brake=0, err=0.
  5. Anything else (mixed direction, or partial overlap) → err=1; cmd and brake hold their previous values.
- Saturation: a line high for all 2^WIN_BITS samples decodes to magnitude 2^WIN_BITS-1. Consequently, drive command -1024 (0x400) decodes as -1023 (0x401); this is intended.
- Between valid pulses, cmd, brake and err are stable.

Optional Feature:
- Macro: MOTOR_DEC_SYNC_EN.
- Defined: fwd and rev each pass through a 2-flop synchronizer, reset to 0, before the accumulators. This adds 2 cycles of sample latency. Window boundaries are unchanged, so the first window contains 2 reset-value (0) samples.
- Undefined: fwd and rev are sampled directly; no added latency.

Test Plan (WIN_BITS=10 unless stated):
- Forward drive 0x100: fwd high 256 of every 1024 cycles, rev=0, window aligned to reset → valid at cycle 1024, cmd=0x100, brake=0, err=0; identical on every later window.
- Reverse drive -1 (0x7FF): rev high 1 cycle per period, unaligned phase, fwd=0 → cmd=0x7FF; saturation case: rev held high for all cycles → cmd=0x401.
- Brake: fwd=rev=1 constantly → brake=1, cmd=0, err=0. Then both low for a full window → brake=0, cmd=0 (coast).
- Direction change mid-window: fwd 0x200 steady state, switched to rev at cycle 500 of a window → that window gives err=1 with cmd held at 0x200; next clean window gives err=0 and cmd=negative magnitude.
- Reset mid-window: rst_n=0 for 1 cycle at wcnt=700 → all outputs 0 on the next edge; next valid 1024 cycles after release.
- MOTOR_DEC_SYNC_EN defined, fwd high constantly from reset → first window cmd=1022, later windows cmd=1023.
